// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative 32-step multiply / restoring divide unit with
// architectural HI/LO registers and pipeline interlock for the EX stage.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [5:0]  i_funct,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    output logic        o_stall,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic [31:0] o_rd_data
);

    localparam int unsigned AWIDTH      = 32;
    localparam int unsigned FUNCT_WIDTH = 6;
    localparam int unsigned CNT_W       = 5;

    localparam logic [FUNCT_WIDTH-1:0] F_MFHI  = 6'h10;
    localparam logic [FUNCT_WIDTH-1:0] F_MTHI  = 6'h11;
    localparam logic [FUNCT_WIDTH-1:0] F_MFLO  = 6'h12;
    localparam logic [FUNCT_WIDTH-1:0] F_MTLO  = 6'h13;
    localparam logic [FUNCT_WIDTH-1:0] F_MULT  = 6'h18;
    localparam logic [FUNCT_WIDTH-1:0] F_MULTU = 6'h19;
    localparam logic [FUNCT_WIDTH-1:0] F_DIV   = 6'h1A;
    localparam logic [FUNCT_WIDTH-1:0] F_DIVU  = 6'h1B;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AWIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [CNT_W-1:0]    r_cnt;
    logic [AWIDTH-1:0]   r_acc;      // product high half / partial remainder
    logic [AWIDTH-1:0]   r_q;        // multiplier / dividend shifting into quotient
    logic [AWIDTH-1:0]   r_b;        // multiplicand / divisor
    logic [AWIDTH-1:0]   r_rs_raw;   // unmodified rs, returned as HI on divide by zero
    logic                r_is_div;
    logic                r_neg_res;
    logic                r_neg_rem;
    logic                r_dz;
    logic [AWIDTH-1:0]   r_hi;
    logic [AWIDTH-1:0]   r_lo;
    logic                r_busy;
    logic                r_done;

    logic                w_is_md;
    logic                w_is_mv;
    logic                w_hilo_op;
    logic                w_accept_md;
    logic                w_signed;
    logic [AWIDTH-1:0]   w_rs_abs;
    logic [AWIDTH-1:0]   w_rt_abs;
    logic [AWIDTH:0]     w_mul_sum;
    logic [AWIDTH:0]     w_div_shift;
    logic                w_div_ge;
    logic [AWIDTH-1:0]   w_div_sub;
    logic [2*AWIDTH-1:0] w_prod;
    logic [2*AWIDTH-1:0] w_prod_fix;
    logic [AWIDTH-1:0]   w_quo_fix;
    logic [AWIDTH-1:0]   w_rem_fix;

    // Request decode, interlock and MFHI/MFLO read port
    always_comb begin
        w_is_md     = (i_funct == F_MULT) || (i_funct == F_MULTU) ||
                      (i_funct == F_DIV)  || (i_funct == F_DIVU);
        w_is_mv     = (i_funct == F_MFHI) || (i_funct == F_MTHI) ||
                      (i_funct == F_MFLO) || (i_funct == F_MTLO);
        w_hilo_op   = i_start && (w_is_md || w_is_mv);
        w_accept_md = w_hilo_op && w_is_md && (r_state == ST_IDLE);
        w_signed    = (i_funct == F_MULT) || (i_funct == F_DIV);
        w_rs_abs    = (w_signed && i_rs[AWIDTH-1]) ? (~i_rs + AWIDTH'(1)) : i_rs;
        w_rt_abs    = (w_signed && i_rt[AWIDTH-1]) ? (~i_rt + AWIDTH'(1)) : i_rt;
        o_stall     = w_hilo_op && r_busy;
        o_rd_data   = '0;
        if (i_start && (i_funct == F_MFHI)) begin
            o_rd_data = r_hi;
        end else if (i_start && (i_funct == F_MFLO)) begin
            o_rd_data = r_lo;
        end
    end

    // One iteration of shift-add multiply and restoring divide, plus sign fixup
    always_comb begin
        w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
        w_div_shift = {r_acc, r_q[AWIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_b});
        w_div_sub   = w_div_shift[AWIDTH-1:0] - r_b;
        w_prod      = {r_acc, r_q};
        w_prod_fix  = r_neg_res ? (~w_prod + (2*AWIDTH)'(1)) : w_prod;
        w_quo_fix   = r_neg_res ? (~r_q + AWIDTH'(1)) : r_q;
        w_rem_fix   = r_neg_rem ? (~r_acc + AWIDTH'(1)) : r_acc;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: if (w_accept_md) w_state_nx = ST_RUN;
            ST_RUN:  if (r_cnt == CNT_LAST) w_state_nx = ST_FIX;
            ST_FIX:  w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and HI/LO writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_b       <= '0;
            r_rs_raw  <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_busy <= (w_state_nx != ST_IDLE);
            r_done <= (r_state == ST_FIX);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept_md) begin
                        r_cnt     <= '0;
                        r_acc     <= '0;
                        r_is_div  <= i_funct[1];
                        r_q       <= i_funct[1] ? w_rs_abs : w_rt_abs;
                        r_b       <= i_funct[1] ? w_rt_abs : w_rs_abs;
                        r_rs_raw  <= i_rs;
                        r_neg_res <= w_signed && (i_rs[AWIDTH-1] ^ i_rt[AWIDTH-1]);
                        r_neg_rem <= w_signed && i_rs[AWIDTH-1];
                        r_dz      <= (i_rt == '0);
                    end else if (w_hilo_op && (i_funct == F_MTHI)) begin
                        r_hi <= i_rs;
                    end else if (w_hilo_op && (i_funct == F_MTLO)) begin
                        r_lo <= i_rs;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_is_div) begin
                        r_acc <= w_div_ge ? w_div_sub : w_div_shift[AWIDTH-1:0];
                        r_q   <= {r_q[AWIDTH-2:0], w_div_ge};
                    end else begin
                        r_acc <= w_mul_sum[AWIDTH:1];
                        r_q   <= {w_mul_sum[0], r_q[AWIDTH-1:1]};
                    end
                end
                ST_FIX: begin
                    if (!r_is_div) begin
                        r_hi <= w_prod_fix[2*AWIDTH-1:AWIDTH];
                        r_lo <= w_prod_fix[AWIDTH-1:0];
                    end else if (r_dz) begin
                        r_hi <= r_rs_raw;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [5:0]  i_funct;
    logic [31:0] i_rs;
    logic [31:0] i_rt;
    logic        o_stall;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic [31:0] o_rd_data;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc;
    int dones;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;

    muldiv_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_funct   (i_funct),
        .i_rs      (i_rs),
        .i_rt      (i_rt),
        .o_stall   (o_stall),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_hi      (o_hi),
        .o_lo      (o_lo),
        .o_rd_data (o_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one mul/div from IDLE, scramble operands afterwards, time it and check results
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
        int c;
        int d;
        @(negedge clk);
        i_start = 1'b1; i_funct = f; i_rs = a; i_rt = b;
        #1 chk({tag, ".issue_stall"}, 32'(o_stall), 32'd0);
        @(negedge clk);
        i_start = 1'b0; i_rs = 32'h5A5A_5A5A; i_rt = 32'hA5A5_A5A5;
        c = 0; d = 0;
        while (o_busy === 1'b1 && c < 40) begin
            c++;
            if (o_done === 1'b1) d++;
            @(negedge clk);
        end
        #1;
        chk({tag, ".busy_cycles"}, 32'(c), 32'd33);
        chk({tag, ".early_done"}, 32'(d), 32'd0);
        chk({tag, ".done"}, 32'(o_done), 32'd1);
        chk({tag, ".hi"}, o_hi, exp_hi);
        chk({tag, ".lo"}, o_lo, exp_lo);
        @(negedge clk);
        #1 chk({tag, ".done_clear"}, 32'(o_done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_funct = '0; i_rs = '0; i_rt = '0;
        repeat (2) @(negedge clk);
        i_start = 1'b1; i_funct = F_MFLO;
        #1;
        chk("rst.busy", 32'(o_busy), 32'd0);
        chk("rst.done", 32'(o_done), 32'd0);
        chk("rst.stall", 32'(o_stall), 32'd0);
        chk("rst.hi", o_hi, 32'd0);
        chk("rst.lo", o_lo, 32'd0);
        @(negedge clk);
        rst = 1'b0; i_start = 1'b0;

        // Arithmetic vectors
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(F_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg");
        run_op(F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minmin");
        run_op(F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
        run_op(F_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, "divu_zero");
        run_op(F_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero_neg");
        run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_ovf");
        run_op(F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu_small");

        // Moves to/from HI/LO while idle; non-HI/LO funct is ignored
        @(negedge clk);
        i_start = 1'b1; i_funct = F_MTHI; i_rs = 32'h0000_1234;
        #1 chk("mthi.stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        i_funct = F_MTLO; i_rs = 32'h0000_ABCD;
        #1 chk("mthi.hi", o_hi, 32'h0000_1234);
        @(negedge clk);
        i_funct = F_MFHI;
        #1 chk("mfhi.rd", o_rd_data, 32'h0000_1234);
        chk("mtlo.lo", o_lo, 32'h0000_ABCD);
        i_funct = F_MFLO;
        #1 chk("mflo.rd", o_rd_data, 32'h0000_ABCD);
        i_funct = F_ADD; i_rs = 32'hDEAD_BEEF;
        #1 chk("add.rd", o_rd_data, 32'd0);
        chk("add.stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        i_start = 1'b0;
        #1;
        chk("add.busy", 32'(o_busy), 32'd0);
        chk("add.hi", o_hi, 32'h0000_1234);
        chk("add.lo", o_lo, 32'h0000_ABCD);

        // MULT 6x7 with ADD during RUN and MFLO held from N+5
        @(negedge clk);
        i_start = 1'b1; i_funct = F_MULT; i_rs = 32'd6; i_rt = 32'd7;
        @(negedge clk);
        i_funct = F_ADD;
        #1;
        chk("mflo_wait.busy", 32'(o_busy), 32'd1);
        chk("mflo_wait.add_stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        i_start = 1'b1; i_funct = F_MFLO;
        cyc = 0;
        #1;
        while (o_stall === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        chk("mflo_wait.stall_cycles", 32'(cyc), 32'd29);
        chk("mflo_wait.stall", 32'(o_stall), 32'd0);
        chk("mflo_wait.rd", o_rd_data, 32'd42);
        chk("mflo_wait.done", 32'(o_done), 32'd1);
        chk("mflo_wait.hi", o_hi, 32'd0);
        @(negedge clk);
        i_start = 1'b0;

        // DIVU stalled behind MULT, then runs with its own operands
        @(negedge clk);
        i_start = 1'b1; i_funct = F_MULT; i_rs = 32'hFFFF_FFFE; i_rt = 32'd5;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_start = 1'b1; i_funct = F_DIVU; i_rs = 32'd100; i_rt = 32'd7;
        cyc = 0;
        #1;
        while (o_stall === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        chk("divu_stall.stall_cycles", 32'(cyc), 32'd31);
        chk("divu_stall.done", 32'(o_done), 32'd1);
        chk("divu_stall.mult_hi", o_hi, 32'hFFFF_FFFF);
        chk("divu_stall.mult_lo", o_lo, 32'hFFFF_FFF6);
        @(negedge clk);
        i_start = 1'b0; i_rs = 32'd3; i_rt = 32'd3;
        cyc = 0;
        while (o_busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        #1;
        chk("divu_stall.busy_cycles", 32'(cyc), 32'd33);
        chk("divu_stall.hi", o_hi, 32'd2);
        chk("divu_stall.lo", o_lo, 32'd14);
        chk("divu_stall.div_done", 32'(o_done), 32'd1);

        // Synchronous reset at RUN counter 10 aborts the operation
        @(negedge clk);
        i_start = 1'b1; i_funct = F_MULTU; i_rs = 32'h1234_5678; i_rt = 32'd9;
        @(negedge clk);
        i_start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; i_start = 1'b1; i_funct = F_MFHI;
        #1;
        chk("abort.busy", 32'(o_busy), 32'd0);
        chk("abort.hi", o_hi, 32'd0);
        chk("abort.lo", o_lo, 32'd0);
        chk("abort.stall", 32'(o_stall), 32'd0);
        chk("abort.done", 32'(o_done), 32'd0);
        @(negedge clk);
        i_start = 1'b0;
        dones = 0;
        repeat (35) begin
            if (o_done === 1'b1 || o_busy === 1'b1) dones++;
            @(negedge clk);
        end
        chk("abort.no_done", 32'(dones), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide controller for the EX stage of the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU from the EX stage and runs an iterative 32-step shift-add multiply or restoring divide on internal registers. Results go to architectural HI/LO registers. It interlocks the pipeline when a HI/LO access or a new multiply/divide arrives while an operation is still in flight.

## Interface
- `AWIDTH` — 32 (header.vh); operand and HI/LO width.
- `FUNCT_WIDTH` — 6; R-type funct field width.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_start  input  1  EX-stage instruction is R-type and valid this cycle.
- i_funct  input  6  funct field: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
- i_rs  input  `AWIDTH`  forwarded rs operand (dividend / multiplicand / MTHI/MTLO data).
- i_rt  input  `AWIDTH`  forwarded rt operand (divisor / multiplier).
- o_stall  output  1  hold IF/ID/EX; request not accepted this cycle.
- o_busy  output  1  operation in flight (state != IDLE).
- o_done  output  1  one-cycle pulse, cycle after HI/LO are written by an operation.
- o_hi, o_lo  output  `AWIDTH`  architectural HI/LO.
- o_rd_data  output  `AWIDTH`  MFHI → o_hi, MFLO → o_lo, else 0.

## Operation
- States: IDLE, RUN, FIX.
- Reset: state IDLE, HI=LO=0, counter 0, o_busy=0, o_done=0, o_stall=0.
- hilo_op = i_start & funct in {the eight codes above}; other functs ignored entirely.
- o_stall = hilo_op & o_busy (combinational); stalled requests retry every cycle and are accepted on the first IDLE cycle.
- IDLE + MULT/MULTU/DIV/DIVU accepted:
  - Latch |rs|, |rt| for signed ops (raw values for unsigned).
  - Record result sign (rs[31]^rt[31]) and remainder sign (rs[31]) for signed ops.
  - counter=0; go RUN. The issuing instruction itself does not stall.
- IDLE + MTHI/MTLO: write i_rs to HI/LO at the edge. MFHI/MFLO: o_rd_data valid same cycle.
- RUN: one bit per cycle, 32 iterations (counter 0..31).
  - Multiply: 64-bit {acc,multiplier} shift-add on the multiplier LSB.
  - Divide: restoring; remainder shifts in one dividend bit, subtract divisor if no borrow, quotient bit = !borrow.
  - At counter 31, go FIX.
- FIX (one cycle): apply signs, write HI/LO at exit edge, go IDLE, assert o_done next cycle.
  - Multiply: negate the 64-bit product if result sign set; HI=upper, LO=lower.
  - Divide: LO=quotient (negated if result sign), HI=remainder (negated if remainder sign).
- Divide by zero (rt==0, signed or unsigned): LO=0xFFFFFFFF, HI=i_rs as latched at issue; no sign fixup. Still takes full latency.
- Signed overflow 0x80000000 / −1: LO=0x80000000, HI=0 (natural result of the abs/negate path).
- Operands are captured at accept; later i_rs/i_rt changes have no effect.
- rst mid-operation aborts: next cycle IDLE, HI/LO=0, no o_done.

## Timing
- Accept at edge N (IDLE, i_start, mul/div funct).
- o_busy high cycles N+1..N+33 (RUN 32 cycles, FIX 1 cycle).
- HI/LO updated at edge ending cycle N+33; o_done high cycle N+34.
- Any HI/LO op in cycles N+1..N+33 → o_stall=1; accepted cycle N+34. MFHI/MFLO then return the new values.
- Back-to-back mul/div: second accepted at N+34 at the earliest.
- o_rd_data, o_stall combinational from current state/inputs; everything else registered.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → o_busy 33 cycles, HI=0xFFFFFFFE, LO=0x00000001, o_done pulse at N+34.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/0 → LO=0xFFFFFFFF, HI=7; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MFLO held 5 cycles after MULT 6×7 → o_stall=1 through N+33, cycle N+34 o_stall=0, o_rd_data=42. MTHI 0x1234 while IDLE → o_hi=0x1234 next cycle.
- rst at RUN counter 10 → next cycle o_busy=0, HI=LO=0, o_stall=0, no o_done.
- Stimuli after MULT accept: DIVU during RUN → stalled, then runs fresh from N+34. i_start with funct 0x20 (ADD) → no stall, no state change.
